// File: rtl/systolic_feeder_pkg.sv
// Shared types and constants for the systolic array operand feeder.
package systolic_feeder_pkg;

  localparam int unsigned DEF_N = 4;
  localparam int unsigned DEF_W = 8;

  localparam logic WR_SEL_A = 1'b0;
  localparam logic WR_SEL_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Operand write port, start request and array-edge operand streams.
interface systolic_feeder_if
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = DEF_W
);

  localparam int unsigned IW = idx_w(N);

  logic            wr_en;
  logic            wr_sel;
  logic [IW-1:0]   wr_row;
  logic [IW-1:0]   wr_col;
  logic [W-1:0]    wr_data;
  logic            start;
  logic [N*W-1:0]  a_out;
  logic [N*W-1:0]  b_out;
  logic [N-1:0]    a_vld;
  logic [N-1:0]    b_vld;
  logic            busy;
  logic            done;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  a_out, b_out, a_vld, b_vld, busy, done
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output a_out, b_out, a_vld, b_vld, busy, done
  );

endinterface

// File: rtl/systolic_feeder_lane.sv
// Per-lane skew select: picks element (beat - lane) of the lane's operand vector.
module feeder_lane #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 3,
  parameter int unsigned LANE  = 0
) (
  input  logic [CNT_W-1:0] i_beat,
  input  logic             i_active,
  input  logic [N*W-1:0]   i_elems,
  output logic [W-1:0]     o_val_c,
  output logic             o_vld_c
);

  logic [CNT_W-1:0] w_diff;
  logic             w_in_range;

  assign w_diff     = i_beat - CNT_W'(LANE);
  assign w_in_range = (i_beat >= CNT_W'(LANE)) && (w_diff < CNT_W'(N));
  assign o_vld_c    = i_active && w_in_range;

  always_comb begin
    o_val_c = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (o_vld_c && (w_diff == CNT_W'(k))) o_val_c = i_elems[k*W +: W];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Stores operand matrices A and B and streams them skewed into an N x N systolic array.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = DEF_W
) (
  input  logic               clk,
  input  logic               rst,
  systolic_feeder_if.slave   bus
);

  localparam int unsigned IW    = idx_w(N);
  localparam int unsigned CNT_W = idx_w(2*N - 1);
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(2*N - 2);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(N - 1);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [W-1:0]      r_a [N][N];
  logic [W-1:0]      r_b [N][N];
  logic [W-1:0]      w_a_eff [N][N];
  logic [W-1:0]      w_b_eff [N][N];
  logic              w_wr_ok;
  logic              w_feed_nxt;
  logic [N*W-1:0]    w_a_val, w_b_val;
  logic [N-1:0]      w_a_vld, w_b_vld;
  logic [N*W-1:0]    r_a_out, r_b_out;
  logic [N-1:0]      r_a_vld, r_b_vld;
  logic              r_busy, r_done;

  assign w_wr_ok = bus.wr_en && !r_busy;

  // Matrices as they will be after this edge, so a write sampled with start reaches beat 0.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        w_a_eff[i][j] = r_a[i][j];
        w_b_eff[i][j] = r_b[i][j];
        if (w_wr_ok && bus.wr_row == IW'(i) && bus.wr_col == IW'(j)) begin
          if (bus.wr_sel == WR_SEL_A) w_a_eff[i][j] = bus.wr_data;
          else                        w_b_eff[i][j] = bus.wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) begin
        for (int j = 0; j < int'(N); j++) begin
          r_a[i][j] <= '0;
          r_b[i][j] <= '0;
        end
      end
    end else begin
      r_a <= w_a_eff;
      r_b <= w_b_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = FEED;
          w_cnt_nxt   = '0;
        end
      end
      FEED: begin
        if (r_cnt == FEED_LAST) begin
          w_state_nxt = FLUSH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      FLUSH: begin
        if (r_cnt == FLUSH_LAST) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_feed_nxt = (w_state_nxt == FEED);

  // Lanes look at the upcoming beat so the registered outputs line up with the state.
  for (genvar g = 0; g < int'(N); g++) begin : g_lane
    logic [N*W-1:0] w_a_row;
    logic [N*W-1:0] w_b_col;

    always_comb begin
      for (int k = 0; k < int'(N); k++) begin
        w_a_row[k*W +: W] = w_a_eff[g][k];
        w_b_col[k*W +: W] = w_b_eff[k][g];
      end
    end

    feeder_lane #(.N(N), .W(W), .CNT_W(CNT_W), .LANE(g)) u_a_lane (
      .i_beat   (w_cnt_nxt),
      .i_active (w_feed_nxt),
      .i_elems  (w_a_row),
      .o_val_c  (w_a_val[g*W +: W]),
      .o_vld_c  (w_a_vld[g])
    );

    feeder_lane #(.N(N), .W(W), .CNT_W(CNT_W), .LANE(g)) u_b_lane (
      .i_beat   (w_cnt_nxt),
      .i_active (w_feed_nxt),
      .i_elems  (w_b_col),
      .o_val_c  (w_b_val[g*W +: W]),
      .o_vld_c  (w_b_vld[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_out <= '0;
      r_b_out <= '0;
      r_a_vld <= '0;
      r_b_vld <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_a_out <= w_a_val;
      r_b_out <= w_b_val;
      r_a_vld <= w_a_vld;
      r_b_vld <= w_b_vld;
      r_busy  <= (w_state_nxt == FEED) || (w_state_nxt == FLUSH);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  assign bus.a_out = r_a_out;
  assign bus.b_out = r_b_out;
  assign bus.a_vld = r_a_vld;
  assign bus.b_vld = r_b_vld;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder against a cycle-indexed skew model.
module tb_systolic_feeder;
  import systolic_feeder_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [W-1:0] m_a [N][N];
  logic [W-1:0] m_b [N][N];

  systolic_feeder_if #(.N(N), .W(W)) bus ();

  systolic_feeder #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_elem(input logic sel, input int row, input int col, input logic [W-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_row  = 2'(row);
    bus.wr_col  = 2'(col);
    bus.wr_data = data;
    step();
    bus.wr_en = 1'b0;
    if (sel == WR_SEL_A) m_a[row][col] = data;
    else                 m_b[row][col] = data;
  endtask

  // Expected outputs in cycle k after the start edge (k=1 carries beat 0).
  task automatic expect_cycle(input int k,
                              output logic [N*W-1:0] ea, output logic [N*W-1:0] eb,
                              output logic [N-1:0] eav, output logic [N-1:0] ebv,
                              output logic ebusy, output logic edone);
    ea = '0; eb = '0; eav = '0; ebv = '0; ebusy = 1'b0; edone = 1'b0;
    if (k >= 1 && k <= 2*N-1) begin
      int t;
      t = k - 1;
      ebusy = 1'b1;
      for (int i = 0; i < int'(N); i++) begin
        int d;
        d = t - i;
        if (d >= 0 && d < int'(N)) begin
          ea[i*W +: W] = m_a[i][d];
          eav[i]       = 1'b1;
          eb[i*W +: W] = m_b[d][i];
          ebv[i]       = 1'b1;
        end
      end
    end else if (k >= 2*N && k <= 3*N-1) begin
      ebusy = 1'b1;
    end else if (k == 3*N) begin
      edone = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag, input int k);
    logic [N*W-1:0] ea, eb;
    logic [N-1:0]   eav, ebv;
    logic           ebusy, edone;
    expect_cycle(k, ea, eb, eav, ebv, ebusy, edone);
    check($sformatf("%s a_out k=%0d", tag, k), 64'(bus.a_out), 64'(ea));
    check($sformatf("%s b_out k=%0d", tag, k), 64'(bus.b_out), 64'(eb));
    check($sformatf("%s a_vld k=%0d", tag, k), 64'(bus.a_vld), 64'(eav));
    check($sformatf("%s b_vld k=%0d", tag, k), 64'(bus.b_vld), 64'(ebv));
    check($sformatf("%s busy k=%0d", tag, k),  64'(bus.busy),  64'(ebusy));
    check($sformatf("%s done k=%0d", tag, k),  64'(bus.done),  64'(edone));
  endtask

  task automatic run_check(input string tag, input bit perturb, input bit wr_first, input bit spec_mode);
    bus.start = 1'b1;
    if (wr_first) begin
      bus.wr_en   = 1'b1;
      bus.wr_sel  = WR_SEL_A;
      bus.wr_row  = '0;
      bus.wr_col  = '0;
      bus.wr_data = 8'd99;
      m_a[0][0]   = 8'd99;
    end
    step();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    for (int k = 1; k <= int'(3*N+1); k++) begin
      check_outputs(tag, k);
      if (spec_mode) begin
        if (k == 1) begin
          check("spec beat0 a_out", 64'(bus.a_out), 64'h0000_0001);
          check("spec beat0 b_out", 64'(bus.b_out), 64'h0000_0010);
        end
        if (k == 4) begin
          check("spec beat3 a_out", 64'(bus.a_out), 64'h0D0A_0704);
          check("spec beat3 b_out", 64'(bus.b_out), 64'h1316_191C);
          check("spec beat3 a_vld", 64'(bus.a_vld), 64'hF);
        end
        if (k == 7) begin
          check("spec beat6 a_out", 64'(bus.a_out), 64'h1000_0000);
          check("spec beat6 b_out", 64'(bus.b_out), 64'h1F00_0000);
        end
        if (k == 12) check("spec done cycle12", 64'(bus.done), 64'h1);
      end
      if (wr_first && k == 1) check("wr+start lane0", 64'(bus.a_out[W-1:0]), 64'd99);
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      if (perturb && k == 3) begin
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'($urandom_range(0, 1));
        bus.wr_row  = 2'($urandom_range(0, N-1));
        bus.wr_col  = 2'($urandom_range(0, N-1));
        bus.wr_data = 8'($urandom);
      end
      if (perturb && k == int'(2*N+1)) bus.start = 1'b1;
      step();
    end
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_row  = '0;
    bus.wr_col  = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    for (int i = 0; i < int'(N); i++)
      for (int j = 0; j < int'(N); j++) begin
        m_a[i][j] = '0;
        m_b[i][j] = '0;
      end
    step(); step(); step();
    check("reset a_out", 64'(bus.a_out), 64'h0);
    check("reset b_out", 64'(bus.b_out), 64'h0);
    check("reset vld",   64'({bus.a_vld, bus.b_vld}), 64'h0);
    check("reset busy",  64'(bus.busy), 64'h0);
    check("reset done",  64'(bus.done), 64'h0);
    rst = 1'b0;
    step();

    // Reference matrices, then the spec-level spot values.
    for (int i = 0; i < int'(N); i++)
      for (int j = 0; j < int'(N); j++) begin
        write_elem(WR_SEL_A, i, j, 8'(4*i + j + 1));
        write_elem(WR_SEL_B, i, j, 8'(16 + 4*i + j));
      end
    run_check("spec", 1'b0, 1'b0, 1'b1);

    // Random contents, a perturbed run, then an undisturbed rerun.
    for (int i = 0; i < int'(N); i++)
      for (int j = 0; j < int'(N); j++) begin
        write_elem(WR_SEL_A, i, j, 8'($urandom));
        write_elem(WR_SEL_B, i, j, 8'($urandom));
      end
    run_check("rand", 1'b0, 1'b0, 1'b0);
    run_check("rand_perturb", 1'b1, 1'b0, 1'b0);
    run_check("rand_rerun", 1'b0, 1'b0, 1'b0);
    run_check("wr_start", 1'b0, 1'b1, 1'b0);

    // Reset at beat 2, together with a write and a start that must both lose.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst         = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_sel  = WR_SEL_A;
    bus.wr_row  = '0;
    bus.wr_col  = '0;
    bus.wr_data = 8'd55;
    bus.start   = 1'b1;
    step();
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    check("abort a_out", 64'(bus.a_out), 64'h0);
    check("abort b_out", 64'(bus.b_out), 64'h0);
    check("abort vld",   64'({bus.a_vld, bus.b_vld}), 64'h0);
    check("abort busy",  64'(bus.busy), 64'h0);
    check("abort done",  64'(bus.done), 64'h0);
    for (int c = 0; c < int'(3*N+2); c++) begin
      check($sformatf("post-abort idle c=%0d", c), 64'({bus.busy, bus.done, bus.a_vld, bus.b_vld}), 64'h0);
      step();
    end
    for (int i = 0; i < int'(N); i++)
      for (int j = 0; j < int'(N); j++) begin
        m_a[i][j] = '0;
        m_b[i][j] = '0;
      end
    run_check("post_rst", 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter N, default 4: systolic array dimension (N x N PEs, N x N operand matrices).
REQ-002 Parameter W, default 8: operand width, matching the 8-bit PE datapath.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  operand write strobe.
REQ-006 wr_sel  input  1  write target: 0 = matrix A, 1 = matrix B.
REQ-007 wr_row, wr_col  input  clog2(N) each  element index; A[row][col] or B[row][col].
REQ-008 wr_data  input  W  element value, unsigned.
REQ-009 start  input  1  request to stream the stored matrices into the array.
REQ-010 a_out  output  N*W  row-edge operands; slice i (bits i*W +: W) drives the a input of PE row i, column 0.
REQ-011 b_out  output  N*W  column-edge operands; slice j drives the b input of PE row 0, column j.
REQ-012 a_vld, b_vld  output  N each  per-lane flag: slice carries a real matrix element.
REQ-013 busy  output  1  high in FEED and FLUSH.
REQ-014 done  output  1  one-cycle pulse when the last operand has drained through the array.

Function
REQ-015 Storage: two N x N arrays of W-bit registers, A and B.
REQ-016 A write occurs when wr_en=1 and busy=0; wr_en while busy is ignored and the stored values are unchanged.
REQ-017 States: IDLE, FEED, FLUSH, DONE.
REQ-018 IDLE -> FEED on start=1; start in any other state is ignored.
REQ-019 If wr_en and start are sampled on the same edge in IDLE, the write is committed and is visible to beat 0.
REQ-020 FEED lasts exactly 2N-1 cycles, beats t = 0..2N-2; beat 0 is presented in the cycle following the edge that sampled start.
REQ-021 Beat t, row lane i: a_out slice i = A[i][t-i] with a_vld[i]=1 if 0 <= t-i < N; otherwise 0 with a_vld[i]=0.
REQ-022 Beat t, column lane j: b_out slice j = B[t-j][j] with b_vld[j]=1 if 0 <= t-j < N; otherwise 0 with b_vld[j]=0.
REQ-023 All outputs are registered, with no combinational path from any input to any output.
REQ-024 FEED -> FLUSH after beat 2N-2.
REQ-025 FLUSH lasts N cycles, with a_out = b_out = 0 and all vld = 0.
REQ-026 FLUSH -> DONE; in DONE, done=1 and busy=0 for exactly one cycle, then DONE -> IDLE.
REQ-027 Start-to-done latency: done is high in cycle 3N after the start edge (cycle 12 for N=4).
REQ-028 In IDLE and DONE, a_out = b_out = 0 and all vld = 0.
REQ-029 Matrix contents persist across runs; a second start with no intervening writes reproduces an identical beat sequence.
REQ-030 The beat counter is sized for 2N-1; no wrap-around is permitted within a phase.

Reset
REQ-031 rst=1 on a clock edge forces IDLE, clears the counter, clears A and B to 0, and drives every output (a_out, b_out, a_vld, b_vld, busy, done) to 0.
REQ-032 rst mid-FEED or mid-FLUSH aborts the run with no done pulse, and streaming halts on the next cycle.
REQ-033 rst takes priority over wr_en and start sampled on the same edge.

Structure
REQ-034 A shared package holds the state enumeration (IDLE, FEED, FLUSH, DONE), the default N and W, and the WR_SEL_A/WR_SEL_B constants.
REQ-035 One sub-module, feeder_lane, implements the per-lane select (beat t, lane index k, selected element -> value and vld).
REQ-036 feeder_lane is instantiated N times for A and N times for B; the FSM and storage reside in systolic_feeder.

Verification (N=4, W=8, A[i][j]=4i+j+1, B[i][j]=16+4i+j)
REQ-037 Load all 32 elements, pulse start -> beat 0: a_out = {0,0,0,1}, a_vld = 0001, b_out lane0 = 16, b_vld = 0001; busy = 1.
REQ-038 Beat 3 -> a_out lanes 0..3 = 4, 7, 10, 13 and a_vld = 1111; b_out lanes 0..3 = 28, 25, 22, 19.
REQ-039 Beat 6 -> only lane 3 is valid: a_out lane3 = 16, b_out lane3 = 31; then 4 zero FLUSH cycles; done pulses in cycle 12 and busy is low.
REQ-040 wr_en writing A[0][0]=99 and start sampled on the same edge in IDLE -> beat 0 a_out lane0 = 99.
REQ-041 wr_en during FEED, and start during FLUSH -> both ignored, stored matrices unchanged, and a rerun matches the previous run.
REQ-042 rst asserted at beat 2 -> next cycle all outputs are 0, the state is IDLE, no done pulse occurs, and A and B read back as 0 on a subsequent start.
